// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default constants for the unified memory-port arbiter.
// Imported by the interface consumers, the picker and the top.
package mem_arb_pkg;

  localparam int DEF_AW           = 32;
  localparam int DEF_DW           = 32;
  localparam int DEF_MEM_LAT      = 1;
  localparam int DEF_STARVE_LIMIT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_C = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side memory port bundle: request/handshake out, grant and read data back.
// The arbiter takes the slave view, each requester the master view.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();

  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);

endinterface

// File: rtl/mem_port_arbiter_arb_pick.sv
// Winner select between the CPU and debug requesters; C has priority unless
// the debug port has waited long enough to be forced through.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic   c_req,
  input  logic   d_req,
  input  logic   starve_hit,
  output logic   pick_valid,
  output owner_t winner
);

  // Priority select with starvation override
  always_comb begin
    pick_valid = c_req | d_req;
    winner     = OWN_C;
    if (starve_hit && d_req) begin
      winner = OWN_D;
    end else if (c_req) begin
      winner = OWN_C;
    end else if (d_req) begin
      winner = OWN_D;
    end else begin
      winner = OWN_C;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the CPU (C) and the debug/loader (D): one
// transaction at a time, fixed read latency, read data routed to the owner.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW           = DEF_AW,
  parameter int DW           = DEF_DW,
  parameter int MEM_LAT      = DEF_MEM_LAT,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave c,
  mem_port_arbiter_if.slave d,
  output logic [AW-1:0]     m_addr,
  output logic              m_we,
  output logic [DW-1:0]     m_wdata,
  input  logic [DW-1:0]     m_rdata,
  output logic              busy
);

  localparam int LW = $clog2(MEM_LAT + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [LW-1:0] LAT_INIT   = LW'(MEM_LAT - 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  arb_state_t    state_r;
  owner_t        owner_r;
  logic [LW-1:0] lat_cnt_r;
  logic [SW-1:0] starve_cnt_r;
  logic          rst_q_r;
  logic [DW-1:0] c_rdata_r;
  logic [DW-1:0] d_rdata_r;

  logic   starve_hit_s;
  logic   pick_valid_s;
  owner_t winner_s;
  logic   blk_s;
  logic   gnt_s;
  logic   win_c_s;
  logic   win_we_s;
  logic   resp_s;
  logic   c_rvalid_s;
  logic   d_rvalid_s;

  assign starve_hit_s = (starve_cnt_r == STARVE_MAX);

  arb_pick u_pick (
    .c_req      (c.req),
    .d_req      (d.req),
    .starve_hit (starve_hit_s),
    .pick_valid (pick_valid_s),
    .winner     (winner_s)
  );

  // Grant, memory drive and read-return routing; quiet during reset and the cycle after
  always_comb begin
    blk_s      = rst | rst_q_r;
    gnt_s      = ~blk_s & pick_valid_s & ((state_r == IDLE) | (state_r == RESP));
    win_c_s    = (winner_s == OWN_C);
    win_we_s   = win_c_s ? c.we : d.we;
    c.gnt      = gnt_s & win_c_s;
    d.gnt      = gnt_s & ~win_c_s;
    m_addr     = gnt_s ? (win_c_s ? c.addr : d.addr) : '0;
    m_wdata    = gnt_s ? (win_c_s ? c.wdata : d.wdata) : '0;
    m_we       = gnt_s & win_we_s;
    resp_s     = ~blk_s & (state_r == RESP);
    c_rvalid_s = resp_s & (owner_r == OWN_C);
    d_rvalid_s = resp_s & (owner_r == OWN_D);
    c.rvalid   = c_rvalid_s;
    d.rvalid   = d_rvalid_s;
    c.rdata    = c_rvalid_s ? m_rdata : c_rdata_r;
    d.rdata    = d_rvalid_s ? m_rdata : d_rdata_r;
    busy       = (state_r != IDLE);
  end

  // Transaction FSM, latency and starvation counters, held read data
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      owner_r      <= OWN_C;
      lat_cnt_r    <= '0;
      starve_cnt_r <= '0;
      rst_q_r      <= 1'b1;
      c_rdata_r    <= '0;
      d_rdata_r    <= '0;
    end else begin
      rst_q_r <= 1'b0;
      if (c_rvalid_s) c_rdata_r <= m_rdata;
      if (d_rvalid_s) d_rdata_r <= m_rdata;
      if (!d.req || d.gnt) begin
        starve_cnt_r <= '0;
      end else if (starve_cnt_r < STARVE_MAX) begin
        starve_cnt_r <= starve_cnt_r + SW'(1);
      end
      case (state_r)
        IDLE, RESP: begin
          // A write finishes in its grant cycle; only reads occupy the port
          if (gnt_s && !win_we_s) begin
            owner_r   <= winner_s;
            lat_cnt_r <= LAT_INIT;
            state_r   <= (MEM_LAT == 1) ? RESP : WAIT;
          end else begin
            state_r <= IDLE;
          end
        end
        WAIT: begin
          if (lat_cnt_r == LW'(1)) begin
            lat_cnt_r <= '0;
            state_r   <= RESP;
          end else begin
            lat_cnt_r <= lat_cnt_r - LW'(1);
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: one instance at MEM_LAT=1 and one at
// MEM_LAT=3, each with a latency-accurate memory model and a read-data scoreboard.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1, rst3;
  mem_port_arbiter_if #(.AW(32), .DW(32)) c1();
  mem_port_arbiter_if #(.AW(32), .DW(32)) d1();
  mem_port_arbiter_if #(.AW(32), .DW(32)) c3();
  mem_port_arbiter_if #(.AW(32), .DW(32)) d3();
  logic [31:0] m_addr1, m_wdata1, m_rdata1, m_addr3, m_wdata3, m_rdata3;
  logic        m_we1, m_we3, busy1, busy3;

  logic        pre_en;
  logic [7:0]  pre_addr;
  logic [31:0] pre_data;
  logic [31:0] mem1 [256];
  logic [31:0] mem3 [256];
  logic [31:0] pipe0, pipe1;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_c1[$], exp_d1[$], exp_c3[$], exp_d3[$];

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .STARVE_LIMIT(4)) u1 (
    .clk(clk), .rst(rst1), .c(c1), .d(d1),
    .m_addr(m_addr1), .m_we(m_we1), .m_wdata(m_wdata1), .m_rdata(m_rdata1), .busy(busy1)
  );

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(3), .STARVE_LIMIT(4)) u3 (
    .clk(clk), .rst(rst3), .c(c3), .d(d3),
    .m_addr(m_addr3), .m_we(m_we3), .m_wdata(m_wdata3), .m_rdata(m_rdata3), .busy(busy3)
  );

  // Single-cycle memory for u1
  always @(posedge clk) begin
    if (pre_en) mem1[pre_addr] <= pre_data;
    else if (m_we1) mem1[m_addr1[7:0]] <= m_wdata1;
    m_rdata1 <= mem1[m_addr1[7:0]];
  end

  // Three-cycle memory for u3
  always @(posedge clk) begin
    if (pre_en) mem3[pre_addr] <= pre_data;
    else if (m_we3) mem3[m_addr3[7:0]] <= m_wdata3;
    pipe0    <= mem3[m_addr3[7:0]];
    pipe1    <= pipe0;
    m_rdata3 <= pipe1;
  end

  // Advance to the next cycle's sample point and retire any read responses
  task automatic step();
    logic [31:0] e;
    @(negedge clk);
    #1;
    if (c1.rvalid === 1'b1) begin
      n_checks++;
      if (exp_c1.size() == 0) begin n_fail++; $display("FAIL sb_c1: unexpected rvalid, rdata=%h", c1.rdata); end
      else begin e = exp_c1.pop_front(); if (c1.rdata !== e) begin n_fail++; $display("FAIL sb_c1: rdata=%h expected=%h", c1.rdata, e); end end
    end
    if (d1.rvalid === 1'b1) begin
      n_checks++;
      if (exp_d1.size() == 0) begin n_fail++; $display("FAIL sb_d1: unexpected rvalid, rdata=%h", d1.rdata); end
      else begin e = exp_d1.pop_front(); if (d1.rdata !== e) begin n_fail++; $display("FAIL sb_d1: rdata=%h expected=%h", d1.rdata, e); end end
    end
    if (c3.rvalid === 1'b1) begin
      n_checks++;
      if (exp_c3.size() == 0) begin n_fail++; $display("FAIL sb_c3: unexpected rvalid, rdata=%h", c3.rdata); end
      else begin e = exp_c3.pop_front(); if (c3.rdata !== e) begin n_fail++; $display("FAIL sb_c3: rdata=%h expected=%h", c3.rdata, e); end end
    end
    if (d3.rvalid === 1'b1) begin
      n_checks++;
      if (exp_d3.size() == 0) begin n_fail++; $display("FAIL sb_d3: unexpected rvalid, rdata=%h", d3.rdata); end
      else begin e = exp_d3.pop_front(); if (d3.rdata !== e) begin n_fail++; $display("FAIL sb_d3: rdata=%h expected=%h", d3.rdata, e); end end
    end
  endtask

  task automatic test_reset();
    logic [7:0]  pa [3];
    logic [31:0] pd [3];
    pa[0] = 8'h10; pd[0] = 32'hDEADBEEF;
    pa[1] = 8'h04; pd[1] = 32'hA5A50004;
    pa[2] = 8'h08; pd[2] = 32'hB0B00008;
    rst1 = 1'b1; rst3 = 1'b1;
    c1.req = 1'b1; c1.addr = 32'h10; c3.req = 1'b1; c3.addr = 32'h4;
    for (int i = 0; i < 3; i++) begin
      step();
      pre_en = 1'b1; pre_addr = pa[i]; pre_data = pd[i];
    end
    step();
    pre_en = 1'b0;
    #1;
    n_checks++; if (c1.gnt !== 1'b0) begin n_fail++; $display("FAIL rst_c1_gnt: got %b want 0", c1.gnt); end
    n_checks++; if (d1.gnt !== 1'b0) begin n_fail++; $display("FAIL rst_d1_gnt: got %b want 0", d1.gnt); end
    n_checks++; if (m_we1 !== 1'b0) begin n_fail++; $display("FAIL rst_m_we: got %b want 0", m_we1); end
    n_checks++; if (m_addr1 !== 32'h0) begin n_fail++; $display("FAIL rst_m_addr: got %h want 0", m_addr1); end
    n_checks++; if (m_wdata1 !== 32'h0) begin n_fail++; $display("FAIL rst_m_wdata: got %h want 0", m_wdata1); end
    n_checks++; if (c1.rdata !== 32'h0) begin n_fail++; $display("FAIL rst_c_rdata: got %h want 0", c1.rdata); end
    n_checks++; if (d1.rdata !== 32'h0) begin n_fail++; $display("FAIL rst_d_rdata: got %h want 0", d1.rdata); end
    n_checks++; if (c3.gnt !== 1'b0) begin n_fail++; $display("FAIL rst_c3_gnt: got %b want 0", c3.gnt); end
    step();
    rst1 = 1'b0; rst3 = 1'b0;
    #1;
    n_checks++; if (c1.gnt !== 1'b0) begin n_fail++; $display("FAIL post_rst_c1_gnt: got %b want 0", c1.gnt); end
    n_checks++; if (c3.gnt !== 1'b0) begin n_fail++; $display("FAIL post_rst_c3_gnt: got %b want 0", c3.gnt); end
    n_checks++; if (c1.rvalid !== 1'b0) begin n_fail++; $display("FAIL post_rst_rvalid: got %b want 0", c1.rvalid); end
    step();
    c1.req = 1'b0; c1.addr = 32'h0; c3.req = 1'b0; c3.addr = 32'h0;
  endtask

  task automatic test_read_lat1();
    step();
    c1.req = 1'b1; c1.we = 1'b0; c1.addr = 32'h10;
    #1;
    n_checks++; if (c1.gnt !== 1'b1) begin n_fail++; $display("FAIL rd1_c_gnt: got %b want 1", c1.gnt); end
    n_checks++; if (d1.gnt !== 1'b0) begin n_fail++; $display("FAIL rd1_d_gnt: got %b want 0", d1.gnt); end
    n_checks++; if (m_addr1 !== 32'h10) begin n_fail++; $display("FAIL rd1_m_addr: got %h want 10", m_addr1); end
    exp_c1.push_back(32'hDEADBEEF);
    step();
    c1.req = 1'b0;
    n_checks++; if (c1.rvalid !== 1'b1) begin n_fail++; $display("FAIL rd1_c_rvalid: got %b want 1", c1.rvalid); end
    n_checks++; if (d1.rvalid !== 1'b0) begin n_fail++; $display("FAIL rd1_d_rvalid: got %b want 0", d1.rvalid); end
    step();
    n_checks++; if (c1.rvalid !== 1'b0) begin n_fail++; $display("FAIL rd1_rvalid_pulse: got %b want 0", c1.rvalid); end
    n_checks++; if (c1.rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd1_rdata_hold: got %h want deadbeef", c1.rdata); end
    n_checks++; if (exp_c1.size() != 0) begin n_fail++; $display("FAIL rd1_drain: %0d reads outstanding, want 0", exp_c1.size()); end
  endtask

  task automatic test_write();
    step();
    d1.req = 1'b1; d1.we = 1'b1; d1.addr = 32'h20; d1.wdata = 32'h12345678;
    #1;
    n_checks++; if (d1.gnt !== 1'b1) begin n_fail++; $display("FAIL wr_d_gnt: got %b want 1", d1.gnt); end
    n_checks++; if (m_we1 !== 1'b1) begin n_fail++; $display("FAIL wr_m_we: got %b want 1", m_we1); end
    n_checks++; if (m_wdata1 !== 32'h12345678) begin n_fail++; $display("FAIL wr_m_wdata: got %h want 12345678", m_wdata1); end
    n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL wr_busy: got %b want 0", busy1); end
    step();
    d1.req = 1'b0; d1.we = 1'b0;
    #1;
    n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL wr_busy_after: got %b want 0", busy1); end
    step();
    d1.req = 1'b1; d1.addr = 32'h20;
    #1;
    n_checks++; if (d1.gnt !== 1'b1) begin n_fail++; $display("FAIL wr_rd_gnt: got %b want 1", d1.gnt); end
    exp_d1.push_back(32'h12345678);
    step();
    d1.req = 1'b0;
    n_checks++; if (d1.rvalid !== 1'b1) begin n_fail++; $display("FAIL wr_rd_rvalid: got %b want 1", d1.rvalid); end
    n_checks++; if (c1.rvalid !== 1'b0) begin n_fail++; $display("FAIL wr_rd_c_rvalid: got %b want 0", c1.rvalid); end
    step();
    n_checks++; if (exp_d1.size() != 0) begin n_fail++; $display("FAIL wr_drain: %0d reads outstanding, want 0", exp_d1.size()); end
  endtask

  task automatic test_back_to_back();
    logic want_d;
    step();
    c1.req = 1'b1; c1.we = 1'b0; c1.addr = 32'h10;
    d1.req = 1'b1; d1.we = 1'b0; d1.addr = 32'h20;
    for (int s = 0; s < 6; s++) begin
      if (s > 0) step();
      #1;
      want_d = (s == 4);
      n_checks++; if (c1.gnt !== !want_d) begin n_fail++; $display("FAIL b2b_c_gnt slot %0d: got %b want %b", s, c1.gnt, !want_d); end
      n_checks++; if (d1.gnt !== want_d) begin n_fail++; $display("FAIL b2b_d_gnt slot %0d: got %b want %b", s, d1.gnt, want_d); end
      if (want_d) exp_d1.push_back(32'h12345678);
      else exp_c1.push_back(32'hDEADBEEF);
      if (s == 5) begin
        n_checks++; if (u1.starve_cnt_r !== 3'd0) begin n_fail++; $display("FAIL b2b_starve_clr: got %0d want 0", u1.starve_cnt_r); end
      end
    end
    step();
    c1.req = 1'b0; d1.req = 1'b0;
    step();
    step();
    n_checks++; if (exp_c1.size() + exp_d1.size() != 0) begin n_fail++; $display("FAIL b2b_drain: %0d reads outstanding, want 0", exp_c1.size() + exp_d1.size()); end
  endtask

  task automatic test_latency();
    step();
    c3.req = 1'b1; c3.we = 1'b0; c3.addr = 32'h4;
    #1;
    n_checks++; if (c3.gnt !== 1'b1) begin n_fail++; $display("FAIL lat_c_gnt: got %b want 1", c3.gnt); end
    exp_c3.push_back(32'hA5A50004);
    for (int k = 1; k < 3; k++) begin
      step();
      c3.req = 1'b0; d3.req = 1'b1; d3.we = 1'b0; d3.addr = 32'h8;
      #1;
      n_checks++; if (d3.gnt !== 1'b0) begin n_fail++; $display("FAIL lat_wait_d_gnt cyc %0d: got %b want 0", k, d3.gnt); end
      n_checks++; if (c3.rvalid !== 1'b0) begin n_fail++; $display("FAIL lat_early_rvalid cyc %0d: got %b want 0", k, c3.rvalid); end
      n_checks++; if (busy3 !== 1'b1) begin n_fail++; $display("FAIL lat_busy cyc %0d: got %b want 1", k, busy3); end
    end
    step();
    #1;
    n_checks++; if (c3.rvalid !== 1'b1) begin n_fail++; $display("FAIL lat_c_rvalid: got %b want 1", c3.rvalid); end
    n_checks++; if (d3.gnt !== 1'b1) begin n_fail++; $display("FAIL lat_resp_d_gnt: got %b want 1", d3.gnt); end
    exp_d3.push_back(32'hB0B00008);
    step();
    d3.req = 1'b0;
    for (int k = 0; k < 3; k++) step();
    n_checks++; if (exp_c3.size() + exp_d3.size() != 0) begin n_fail++; $display("FAIL lat_drain: %0d reads outstanding, want 0", exp_c3.size() + exp_d3.size()); end
  endtask

  task automatic test_reset_mid_read();
    step();
    c3.req = 1'b1; c3.we = 1'b0; c3.addr = 32'h4;
    #1;
    n_checks++; if (c3.gnt !== 1'b1) begin n_fail++; $display("FAIL mid_c_gnt: got %b want 1", c3.gnt); end
    step();
    c3.req = 1'b0; rst3 = 1'b1;
    step();
    rst3 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step();
      n_checks++; if (c3.rvalid !== 1'b0) begin n_fail++; $display("FAIL mid_no_rvalid cyc %0d: got %b want 0", k, c3.rvalid); end
      n_checks++; if (busy3 !== 1'b0) begin n_fail++; $display("FAIL mid_idle cyc %0d: got %b want 0", k, busy3); end
    end
    step();
    c3.req = 1'b1;
    #1;
    n_checks++; if (c3.gnt !== 1'b1) begin n_fail++; $display("FAIL mid_next_gnt: got %b want 1", c3.gnt); end
    exp_c3.push_back(32'hA5A50004);
    step();
    c3.req = 1'b0;
    for (int k = 0; k < 4; k++) step();
    n_checks++; if (exp_c3.size() != 0) begin n_fail++; $display("FAIL mid_drain: %0d reads outstanding, want 0", exp_c3.size()); end
  endtask

  task automatic test_cancel();
    step();
    c1.req = 1'b1; c1.we = 1'b0; c1.addr = 32'h10;
    d1.req = 1'b1; d1.we = 1'b0; d1.addr = 32'h20;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) step();
      if (k == 2) d1.req = 1'b0;
      #1;
      n_checks++; if (c1.gnt !== 1'b1) begin n_fail++; $display("FAIL cancel_c_gnt cyc %0d: got %b want 1", k, c1.gnt); end
      n_checks++; if (d1.gnt !== 1'b0) begin n_fail++; $display("FAIL cancel_d_gnt cyc %0d: got %b want 0", k, d1.gnt); end
      exp_c1.push_back(32'hDEADBEEF);
    end
    step();
    c1.req = 1'b0;
    n_checks++; if (u1.starve_cnt_r !== 3'd0) begin n_fail++; $display("FAIL cancel_starve: got %0d want 0", u1.starve_cnt_r); end
    step();
    step();
    n_checks++; if (d1.rvalid !== 1'b0) begin n_fail++; $display("FAIL cancel_d_rvalid: got %b want 0", d1.rvalid); end
    n_checks++; if (exp_c1.size() + exp_d1.size() != 0) begin n_fail++; $display("FAIL cancel_drain: %0d reads outstanding, want 0", exp_c1.size() + exp_d1.size()); end
  endtask

  initial begin
    rst1 = 1'b1; rst3 = 1'b1;
    pre_en = 1'b0; pre_addr = 8'h0; pre_data = 32'h0;
    c1.req = 1'b0; c1.we = 1'b0; c1.addr = 32'h0; c1.wdata = 32'h0;
    d1.req = 1'b0; d1.we = 1'b0; d1.addr = 32'h0; d1.wdata = 32'h0;
    c3.req = 1'b0; c3.we = 1'b0; c3.addr = 32'h0; c3.wdata = 32'h0;
    d3.req = 1'b0; d3.we = 1'b0; d3.addr = 32'h0; d3.wdata = 32'h0;
    test_reset();
    test_read_lat1();
    test_write();
    test_back_to_back();
    test_latency();
    test_reset_mid_read();
    test_cancel();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between two requesters: the multi-cycle CPU (port C, instruction fetch and load/store) and the debug/loader engine (port D, program load and memory dump).
- Sits between the CPU's memory-address mux and the `mem` instance.
- Issues one transaction at a time, tracks fixed read latency and routes read data back to the owner.
- Fixed priority to C, with a starvation guard for D.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MEM_LAT, 1, cycles from address issue to valid m_rdata (>=1).
- STARVE_LIMIT, 4, consecutive cycles D may wait while requesting before it is forced to win.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- c_req  in  1  CPU request; held until c_gnt.
- c_we  in  1  CPU write enable (1 = write).
- c_addr  in  AW  CPU address.
- c_wdata  in  DW  CPU write data.
- c_gnt  out  1  CPU request accepted this cycle.
- c_rvalid  out  1  CPU read data valid (1-cycle pulse).
- c_rdata  out  DW  CPU read data.
- d_req, d_we, d_addr, d_wdata, d_gnt, d_rvalid, d_rdata: same as the C port, for the debug/loader.
- m_addr  out  AW  memory address.
- m_we  out  1  memory write enable.
- m_wdata  out  DW  memory write data.
- m_rdata  in  DW  memory read data.
- busy  out  1  read in flight (state != IDLE).

Behaviour:
- Reset: state IDLE; lat_cnt=0; starve_cnt=0; owner=C.
  - All gnt, rvalid and m_we are 0 during the rst cycle and the cycle after it.
  - m_addr and m_wdata are 0; c_rdata and d_rdata are 0.
- States: IDLE, WAIT, RESP.
- Arbitration is evaluated in IDLE and RESP only.
  - The winner is D if starve_cnt==STARVE_LIMIT and d_req; else C if c_req; else D if d_req.
  - gnt is combinational and asserted in the same cycle.
  - m_addr, m_we and m_wdata are driven from the winner in that cycle.
  - m_we = winner_we & gnt.
- Write grant: completes in the grant cycle; no response; next state IDLE.
- Read grant:
  - owner <= winner; lat_cnt <= MEM_LAT-1.
  - Next state is RESP if MEM_LAT==1, else WAIT.
- WAIT: lat_cnt decrements each cycle; go to RESP when lat_cnt reaches 1. No grants. m_we=0.
- RESP:
  - owner's rvalid=1 and owner's rdata=m_rdata; the other port's rvalid=0.
  - A new grant may issue in the same cycle (back-to-back reads: one read per MEM_LAT cycles when MEM_LAT==1).
  - Next state follows the new grant, else IDLE.
- rdata outputs hold their last delivered value when rvalid=0.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) on each cycle with d_req=1 and d_gnt=0.
  - Clears on d_gnt, and also clears when d_req=0.
- Simultaneous c_req and d_req with starve_cnt < STARVE_LIMIT: C wins.
- A requester may drop req before gnt (cancel); no side effect beyond the starvation-counter clear.
- req asserted while the arbiter is in WAIT is simply held; gnt follows in RESP at the earliest.
- Reset mid-read: the in-flight read is discarded, no rvalid is produced, and the state returns to IDLE.
- Address and data are passed unmodified; word alignment is the requester's responsibility.
- Never more than one gnt high per cycle; never more than one read outstanding.

Decomposition:
- Shared package `mem_arb_pkg`:
  - typedef enum logic[1:0] arb_state_t {IDLE, WAIT, RESP}.
  - typedef enum logic owner_t {OWN_C, OWN_D}.
  - Default-parameter constants.
- One sub-module, `arb_pick`: combinational winner select from (c_req, d_req, starve_hit).
- The FSM, latency counter and starvation counter stay in the top module.

Test Plan:
- Read, MEM_LAT=1: mem[0x10]=0xDEADBEEF; c_req read addr 0x10 at cycle 0 -> c_gnt at cycle 0, c_rvalid and c_rdata=0xDEADBEEF at cycle 1, d_rvalid=0.
- Write: d_req write addr 0x20 data 0x12345678 -> d_gnt and m_we=1 in the same cycle; a subsequent d read of 0x20 returns 0x12345678; busy stays 0 for the write.
- Contention: c_req and d_req both held continuously for back-to-back reads, STARVE_LIMIT=4 ->
  - C granted in 4 consecutive arbitration slots, D granted in the 5th.
  - starve_cnt returns to 0; C wins the following slot.
- Latency: MEM_LAT=3, c read of 0x4 -> c_rvalid exactly 3 cycles after c_gnt; no gnt in the WAIT cycles even with d_req=1; d_gnt in the RESP cycle.
- Reset mid-read: MEM_LAT=3, rst=1 one cycle after c_gnt -> no c_rvalid ever produced for that read; state IDLE; the next c read completes normally.
- Cancel: d_req high for 2 cycles while C owns the port, then dropped -> d_gnt never asserts and starve_cnt returns to 0.
